// File: rtl/mp_arb_pkg.sv
// mp_arb_pkg
// Purpose: shared types and constants for the frame SRAM arbiter.
//   req_idx_e : requester index (display, motion-predict, background learner)
//   state_e   : arbiter FSM states
//   tag_t     : read-return tag {valid, owner}
//   owner_onehot(): converts a requester index into a one-hot vector
package mp_arb_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        REQ_DISP = 2'd0,
        REQ_MP   = 2'd1,
        REQ_BG   = 2'd2
    } req_idx_e;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] owner;
    } tag_t;

    function automatic logic [2:0] owner_onehot(input logic [1:0] owner);
        return 3'b001 << owner;
    endfunction

endpackage

// File: rtl/mp_rd_tag_pipe.sv
// mp_rd_tag_pipe
// Purpose: shift register of read tags that follows each memory command
//   through the SRAM latency so read data can be routed to its owner.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (clears all tags)
//   i_tag          : tag entered every cycle (valid=0 for writes / idle)
//   o_head         : oldest stage, aligned with i_mem_rdata
//   o_empty        : no valid tag anywhere in the pipe
module mp_rd_tag_pipe
    import mp_arb_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  tag_t i_tag,
    output tag_t o_head,
    output logic o_empty
);

    tag_t pipe_q [DEPTH];
    tag_t pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = i_tag;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    always_comb begin
        o_empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_q[i].valid) begin
                o_empty = 1'b0;
            end
        end
    end

    assign o_head = pipe_q[DEPTH-1];

endmodule

// File: rtl/mp_frame_mem_arbiter.sv
// mp_frame_mem_arbiter
// Purpose: shares one single-port frame SRAM between display scan-out
//   (REQ0, priority), motion-predict fetch (REQ1) and background learner
//   (REQ2). One command per cycle, read data routed back in issue order,
//   display starvation guard, drain/halt mode for safe frame switching.
// Ports:
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_req/i_we/i_addr/i_wdata : per-requester request, write enable, address, data
//   o_gnt                 : one-hot combinational accept
//   o_rvalid/o_rdata      : registered read return (one-hot owner, shared data)
//   i_drain/o_drained     : stop granting and flush reads / halted indication
//   o_mem_en/we/addr/wdata: registered SRAM command
//   i_mem_rdata           : SRAM read data, RD_LAT cycles after command
// Optional feature: define ARB_STATS_EN to add o_stat_gnt0/1/2 (grant counts)
//   and o_stat_hog (cycles the starvation guard forced a low grant).
module mp_frame_mem_arbiter
    import mp_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_LAT  = 2,
    parameter int MAX_HOG = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [2:0]             i_req,
    input  logic [2:0]             i_we,
    input  logic [2:0][ADDR_W-1:0] i_addr,
    input  logic [2:0][DATA_W-1:0] i_wdata,
    output logic [2:0]             o_gnt,
    output logic [2:0]             o_rvalid,
    output logic [DATA_W-1:0]      o_rdata,
    input  logic                   i_drain,
    output logic                   o_drained,
    output logic                   o_mem_en,
    output logic                   o_mem_we,
    output logic [ADDR_W-1:0]      o_mem_addr,
    output logic [DATA_W-1:0]      o_mem_wdata,
    input  logic [DATA_W-1:0]      i_mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]            o_stat_gnt0,
    output logic [31:0]            o_stat_gnt1,
    output logic [31:0]            o_stat_gnt2,
    output logic [15:0]            o_stat_hog
`endif
);

    localparam int              HOG_W   = $clog2(MAX_HOG + 1);
    localparam logic [HOG_W-1:0] HOG_MAX = HOG_W'(MAX_HOG);

    state_e             state_q, state_d;
    req_idx_e           rr_ptr_q, rr_ptr_d;
    logic [HOG_W-1:0]   hog_q, hog_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [2:0]         rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic [2:0]         gnt;
    logic [1:0]         gnt_idx;
    logic               low_req;
    logic               grant_ok;
    tag_t               tag_in;
    tag_t               tag_head;
    logic               tag_empty;

    assign low_req = i_req[1] | i_req[2];
    // Reset and any non-RUN state (or a drain request this very cycle) block grants.
    assign grant_ok = i_rst_n && (state_q == S_RUN) && !i_drain;

    // Arbitration, starvation guard and FSM next state
    always_comb begin
        gnt      = 3'b000;
        rr_ptr_d = rr_ptr_q;
        hog_d    = hog_q;
        state_d  = state_q;

        if (grant_ok) begin
            // Display wins unless it has hogged MAX_HOG slots while a low requester waits.
            if (i_req[0] && (hog_q != HOG_MAX || !low_req)) begin
                gnt = 3'b001;
            end else if (i_req[1] && i_req[2]) begin
                gnt = (rr_ptr_q == REQ_BG) ? 3'b100 : 3'b010;
            end else if (i_req[1]) begin
                gnt = 3'b010;
            end else if (i_req[2]) begin
                gnt = 3'b100;
            end
        end

        if (gnt[1]) begin
            rr_ptr_d = REQ_BG;
        end else if (gnt[2]) begin
            rr_ptr_d = REQ_MP;
        end

        if (gnt[1] || gnt[2] || !low_req) begin
            hog_d = '0;
        end else if (gnt[0] && hog_q != HOG_MAX) begin
            hog_d = hog_q + 1'b1;
        end

        case (state_q)
            S_RUN:   if (i_drain) state_d = S_DRAIN;
            S_DRAIN: begin
                if (!i_drain) begin
                    state_d = S_RUN;
                end else if (tag_empty) begin
                    state_d = S_HALT;
                end
            end
            S_HALT:  if (!i_drain) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // Command formation; address/data hold when idle so only the strobe toggles.
    always_comb begin
        gnt_idx     = gnt[2] ? 2'd2 : (gnt[1] ? 2'd1 : 2'd0);
        mem_en_d    = |gnt;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (|gnt) begin
            mem_we_d    = (gnt_idx != 2'd0) && i_we[gnt_idx];
            mem_addr_d  = i_addr[gnt_idx];
            mem_wdata_d = i_wdata[gnt_idx];
        end
        tag_in.valid = (|gnt) && !mem_we_d;
        tag_in.owner = gnt_idx;
    end

    // Read return: head tag lines up with i_mem_rdata.
    always_comb begin
        rvalid_d = 3'b000;
        rdata_d  = rdata_q;
        if (tag_head.valid) begin
            rvalid_d = owner_onehot(tag_head.owner);
            rdata_d  = i_mem_rdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_RUN;
            rr_ptr_q    <= REQ_MP;
            hog_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rvalid_q    <= 3'b000;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hog_q       <= hog_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    mp_rd_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_tag_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_tag   (tag_in),
        .o_head  (tag_head),
        .o_empty (tag_empty)
    );

`ifdef ARB_STATS_EN
    logic [31:0] stat_gnt0_q, stat_gnt0_d;
    logic [31:0] stat_gnt1_q, stat_gnt1_d;
    logic [31:0] stat_gnt2_q, stat_gnt2_d;
    logic [15:0] stat_hog_q,  stat_hog_d;

    always_comb begin
        stat_gnt0_d = stat_gnt0_q + {31'd0, gnt[0]};
        stat_gnt1_d = stat_gnt1_q + {31'd0, gnt[1]};
        stat_gnt2_d = stat_gnt2_q + {31'd0, gnt[2]};
        stat_hog_d  = stat_hog_q;
        // A low grant while display is requesting can only come from the guard.
        if (i_req[0] && (gnt[1] || gnt[2]) && stat_hog_q != 16'hFFFF) begin
            stat_hog_d = stat_hog_q + 16'd1;
        end
        if (state_q != S_HALT && state_d == S_HALT) begin
            stat_gnt0_d = '0;
            stat_gnt1_d = '0;
            stat_gnt2_d = '0;
            stat_hog_d  = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stat_gnt0_q <= '0;
            stat_gnt1_q <= '0;
            stat_gnt2_q <= '0;
            stat_hog_q  <= '0;
        end else begin
            stat_gnt0_q <= stat_gnt0_d;
            stat_gnt1_q <= stat_gnt1_d;
            stat_gnt2_q <= stat_gnt2_d;
            stat_hog_q  <= stat_hog_d;
        end
    end

    assign o_stat_gnt0 = stat_gnt0_q;
    assign o_stat_gnt1 = stat_gnt1_q;
    assign o_stat_gnt2 = stat_gnt2_q;
    assign o_stat_hog  = stat_hog_q;
`endif

    assign o_gnt       = gnt;
    assign o_rvalid    = rvalid_q;
    assign o_rdata     = rdata_q;
    assign o_drained   = (state_q == S_HALT);
    assign o_mem_en    = mem_en_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mp_frame_mem_arbiter.sv
// Directed bench for mp_frame_mem_arbiter (default parameters, RD_LAT=2, MAX_HOG=4).
// Inputs change on the falling edge; o_gnt is checked 1 time unit later,
// registered outputs are checked on the falling edge.
module tb_mp_frame_mem_arbiter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        req;
    logic [2:0]        we;
    logic [2:0][19:0]  addr;
    logic [2:0][15:0]  wdata;
    logic              drain;
    logic [2:0]        gnt;
    logic [2:0]        rvalid;
    logic [15:0]       rdata;
    logic              drained;
    logic              mem_en;
    logic              mem_we;
    logic [19:0]       mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
`ifdef ARB_STATS_EN
    logic [31:0]       stat_gnt0, stat_gnt1, stat_gnt2;
    logic [15:0]       stat_hog;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mp_frame_mem_arbiter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_we        (we),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_gnt       (gnt),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .i_drain     (drain),
        .o_drained   (drained),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
`ifdef ARB_STATS_EN
        ,
        .o_stat_gnt0 (stat_gnt0),
        .o_stat_gnt1 (stat_gnt1),
        .o_stat_gnt2 (stat_gnt2),
        .o_stat_hog  (stat_hog)
`endif
    );

    // SRAM model: 256 words (low address bits), read latency 2 from command on pins.
    logic [15:0] mem [256];
    logic [15:0] rd_p1, rd_p2;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
            mem[8'h23] <= 16'hBEEF;
            rd_p1 <= '0;
            rd_p2 <= '0;
        end else begin
            if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            rd_p1 <= mem[mem_addr[7:0]];
            rd_p2 <= rd_p1;
        end
    end
    assign mem_rdata = rd_p2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 3'b111;
        we    = 3'b000;
        addr  = '0;
        wdata = '0;
        drain = 1'b0;

        // Reset with all requests asserted
        repeat (3) @(negedge clk);
        chk("rst_gnt",      32'(gnt),       32'h0);
        chk("rst_rvalid",   32'(rvalid),    32'h0);
        chk("rst_rdata",    32'(rdata),     32'h0);
        chk("rst_drained",  32'(drained),   32'h0);
        chk("rst_mem_en",   32'(mem_en),    32'h0);
        chk("rst_mem_we",   32'(mem_we),    32'h0);
        chk("rst_mem_addr", 32'(mem_addr),  32'h0);
        chk("rst_mem_wd",   32'(mem_wdata), 32'h0);
        rst_n = 1'b1;
        #1 chk("first_gnt", 32'(gnt), 32'h1);

        // Round-robin between REQ1/REQ2, pointer starts at REQ1
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req = 3'b110;
            #1 chk("rr_gnt", 32'(gnt), (i % 2 == 0) ? 32'h2 : 32'h4);
        end

        // Starvation guard: 4 display grants then one REQ1 grant
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req = 3'b011;
            #1 chk("hog_gnt", 32'(gnt), (i % 5 == 4) ? 32'h2 : 32'h1);
        end

        @(negedge clk);
        req = 3'b000;
        #1 chk("idle_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        chk("idle_mem_en", 32'(mem_en), 32'h0);
        repeat (5) @(negedge clk);

        // Read latency: REQ1 read of 0x00123 -> 0xBEEF four cycles after grant
        @(negedge clk);
        req = 3'b010;
        addr[1] = 20'h00123;
        #1 chk("lat_gnt", 32'(gnt), 32'h2);
        @(negedge clk);
        req = 3'b000;
        chk("lat_mem_en",   32'(mem_en),   32'h1);
        chk("lat_mem_we",   32'(mem_we),   32'h0);
        chk("lat_mem_addr", 32'(mem_addr), 32'h00123);
        @(negedge clk);
        chk("lat_t2_en",     32'(mem_en), 32'h0);
        chk("lat_t2_rvalid", 32'(rvalid), 32'h0);
        @(negedge clk);
        chk("lat_t3_rvalid", 32'(rvalid), 32'h0);
        @(negedge clk);
        chk("lat_t4_rvalid", 32'(rvalid), 32'h2);
        chk("lat_t4_rdata",  32'(rdata),  32'hBEEF);
        @(negedge clk);
        chk("lat_t5_rvalid", 32'(rvalid), 32'h0);

        // REQ2 write: command out, no read return
        @(negedge clk);
        req = 3'b100;
        we  = 3'b100;
        addr[2]  = 20'h00045;
        wdata[2] = 16'h1234;
        #1 chk("wr_gnt", 32'(gnt), 32'h4);
        @(negedge clk);
        req = 3'b000;
        we  = 3'b000;
        chk("wr_mem_en",   32'(mem_en),    32'h1);
        chk("wr_mem_we",   32'(mem_we),    32'h1);
        chk("wr_mem_addr", 32'(mem_addr),  32'h00045);
        chk("wr_mem_wd",   32'(mem_wdata), 32'h1234);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wr_no_rvalid", 32'(rvalid), 32'h0);
        end

        // REQ2 reads back the written word
        @(negedge clk);
        req = 3'b100;
        #1 chk("rb_gnt", 32'(gnt), 32'h4);
        @(negedge clk);
        req = 3'b000;
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("rb_rvalid", 32'(rvalid), 32'h4);
        chk("rb_rdata",  32'(rdata),  32'h1234);
        repeat (2) @(negedge clk);

        // Drain: three display reads back-to-back, then drain with request held
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req = 3'b001;
            addr[0] = 20'h00010 + 20'(i);
            #1 chk("drn_issue_gnt", 32'(gnt), 32'h1);
        end
        @(negedge clk);
        drain = 1'b1;
        chk("drn_t3_rvalid", 32'(rvalid), 32'h0);
        #1 chk("drn_same_cycle_gnt", 32'(gnt), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drn_rvalid",  32'(rvalid),  (i < 3) ? 32'h1 : 32'h0);
            chk("drn_drained", 32'(drained), (i == 3) ? 32'h1 : 32'h0);
            if (i < 3) chk("drn_rdata", 32'(rdata), 32'hA010 + 32'(i));
            #1 chk("drn_gnt", 32'(gnt), 32'h0);
        end
        @(negedge clk);
        chk("halt_drained", 32'(drained), 32'h1);
        drain = 1'b0;
        #1 chk("halt_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        chk("resume_drained", 32'(drained), 32'h0);
        #1 chk("resume_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        req = 3'b000;

        // Reset with a read in flight: it must never return
        @(negedge clk);
        req = 3'b010;
        addr[1] = 20'h00023;
        #1 chk("rstmid_gnt", 32'(gnt), 32'h2);
        @(negedge clk);
        req = 3'b000;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rstmid_rvalid", 32'(rvalid), 32'h0);
        end

`ifdef ARB_STATS_EN
        // Statistics: ten display-only grants after a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 3'b001;
        repeat (9) @(negedge clk);
        @(negedge clk);
        req = 3'b000;
        chk("stat_gnt0", stat_gnt0,        32'd10);
        chk("stat_gnt1", stat_gnt1,        32'd0);
        chk("stat_gnt2", stat_gnt2,        32'd0);
        chk("stat_hog",  32'(stat_hog),    32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
